// File: rtl/mc_control_fsm.sv
// Multi-cycle control unit: sequences fetch/decode/execute/memory/writeback and
// decodes opcode/funct into ALU and datapath controls with a timed memory handshake.
module mc_control_fsm #(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zout,
    input  logic       mem_ready,
    output logic [3:0] alu_ctrl,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       bus_err
);

    typedef enum logic [3:0] {
        StIdle, StFetch, StDecode, StRExec, StRWb, StMemAddr, StMemRead, StMemWb,
        StMemWrite, StBranch, StAddiExec, StAddiWb, StJump, StHalt
    } state_e;

    localparam logic [5:0] OpR    = 6'b000000;
    localparam logic [5:0] OpLw   = 6'b100011;
    localparam logic [5:0] OpSw   = 6'b101011;
    localparam logic [5:0] OpBeq  = 6'b000100;
    localparam logic [5:0] OpAddi = 6'b001000;
    localparam logic [5:0] OpJ    = 6'b000010;

    localparam logic [3:0] AluAdd = 4'b0000;
    localparam logic [3:0] AluSub = 4'b0010;
    localparam logic [3:0] AluAnd = 4'b0100;
    localparam logic [3:0] AluNor = 4'b0101;
    localparam logic [3:0] AluSll = 4'b1010;
    localparam logic [3:0] AluSrl = 4'b1011;

    localparam bit         TimeoutEn = (WAIT_LIMIT != 0);
    localparam logic [7:0] LimitM1   = 8'(WAIT_LIMIT - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       bus_err_q, bus_err_d;
    logic [3:0] r_alu;
    logic       r_ok;
    logic       mem_state;
    logic       wait_hit;

    always_comb begin
        r_alu = AluAdd;
        r_ok  = 1'b1;
        case (funct)
            6'b100000: r_alu = AluAdd;
            6'b100010: r_alu = AluSub;
            6'b100100: r_alu = AluAnd;
            6'b100111: r_alu = AluNor;
            6'b000000: r_alu = AluSll;
            6'b000010: r_alu = AluSrl;
            default:   r_ok  = 1'b0;
        endcase
    end

    assign mem_state = (state_q == StFetch) || (state_q == StMemRead) ||
                       (state_q == StMemWrite);
    // This cycle would be the WAIT_LIMIT-th consecutive stalled cycle.
    assign wait_hit  = TimeoutEn && mem_state && !mem_ready && (wait_q == LimitM1);

    always_comb begin
        wait_d = wait_q;
        if (!mem_state || mem_ready) begin
            wait_d = 8'd0;
        end else if (wait_q != 8'hff) begin
            wait_d = wait_q + 8'd1;
        end
        bus_err_d = bus_err_q | wait_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            wait_q    <= 8'd0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        alu_ctrl   = AluAdd;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                if (wait_hit) begin
                    state_d = StHalt;
                end else if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OpR: begin
                        if (r_ok) begin
                            state_d = StRExec;
                        end else begin
                            illegal_op = 1'b1;
                            state_d    = StFetch;
                        end
                    end
                    OpLw, OpSw: state_d = StMemAddr;
                    OpBeq:      state_d = StBranch;
                    OpAddi:     state_d = StAddiExec;
                    OpJ:        state_d = StJump;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = StFetch;
                    end
                endcase
            end
            StRExec: begin
                alu_src_a = 1'b1;
                alu_ctrl  = r_alu;
                state_d   = StRWb;
            end
            StRWb: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OpSw) ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (wait_hit) begin
                    state_d = StHalt;
                end else if (mem_ready) begin
                    state_d = StMemWb;
                end
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StMemWrite: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (wait_hit) begin
                    state_d = StHalt;
                end else if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = StFetch;
                end
            end
            StBranch: begin
                alu_src_a  = 1'b1;
                alu_ctrl   = AluSub;
                pc_src     = 2'b01;
                pc_en      = zout;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StAddiExec: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = StAddiWb;
            end
            StAddiWb: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StJump: begin
                pc_src     = 2'b10;
                pc_en      = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    assign bus_err = bus_err_q;

endmodule
